vg75_rowfetch: RTL and testbench

- Text-row fetch stage directly upstream of the VGA timing and pixel generator.
- Reads one text row of character codes from video RAM (Radio-86RK layout) into a ping-pong line buffer during the previous row's display.
- Presents the code for the current column to the font and pixel stage with fixed latency.
- Display geometry is 80 columns x 25 rows; each row is 16 scanlines on the 640x400 raster.

---
 rtl/vg75_rowfetch.sv | 182 ++++++++++++++++++
 tb/tb_vg75_rowfetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vg75_rowfetch.sv
// Text-row fetch stage: pulls one row of character codes from video RAM into a
// ping-pong line buffer. Optional cursor compare: define VG75_ROWFETCH_CURSOR_EN.
module vg75_rowfetch #(
    parameter int          COLS      = 80,
    parameter int          ROWS      = 25,
    parameter logic [15:0] BASE_ADDR = 16'h76D0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        row_swap,
    input  logic [6:0]  col,
`ifdef VG75_ROWFETCH_CURSOR_EN
    input  logic [4:0]  cursor_row,
    input  logic [6:0]  cursor_col,
    output logic        cursor,
`endif
    output logic [7:0]  char_code,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        fetch_busy,
    output logic        underrun
);

    localparam logic [6:0]  C_LAST   = 7'(COLS - 1);
    localparam logic [6:0]  C_COLS   = 7'(COLS);
    localparam logic [15:0] C_STRIDE = 16'(COLS);
    localparam logic [4:0]  C_ROWS   = 5'(ROWS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_RESTART
    } state_t;

    state_t      r_state;
    logic [6:0]  r_idx;
    logic [4:0]  r_row_ptr;
    logic [15:0] r_row_base;
    logic [15:0] r_mem_addr;
    logic        r_mem_req;
    logic        r_front_sel;
    logic        r_underrun;
    logic [7:0]  r_char_code;
    logic [7:0]  r_buf0 [COLS];
    logic [7:0]  r_buf1 [COLS];

    logic        w_ack;
    logic        w_swap;
    logic [4:0]  w_ptr;
    logic [15:0] w_base;
    logic        w_can_fetch;
    logic        w_start;
    logic [7:0]  w_front_byte;

    assign w_ack  = r_mem_req & mem_ack;
    assign w_swap = row_swap & ~frame_start;

    // frame_start rewinds the row pointer in the same cycle it may start row 0
    assign w_ptr       = frame_start ? 5'd0 : r_row_ptr;
    assign w_base      = frame_start ? BASE_ADDR : r_row_base;
    assign w_can_fetch = (w_ptr < C_ROWS);
    assign w_start     = ((r_state == S_IDLE) && (frame_start || (row_swap && w_can_fetch))) ||
                         ((r_state == S_RESTART) && w_can_fetch);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 7'd0;
            r_row_ptr   <= 5'd0;
            r_row_base  <= BASE_ADDR;
            r_mem_addr  <= BASE_ADDR;
            r_mem_req   <= 1'b0;
            r_front_sel <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            if (frame_start)
                r_underrun <= 1'b0;
            else if (row_swap && (r_state != S_IDLE))
                r_underrun <= 1'b1;

            if (w_swap)
                r_front_sel <= ~r_front_sel;

            if (frame_start) begin
                r_row_ptr  <= 5'd0;
                r_row_base <= BASE_ADDR;
            end

            case (r_state)
                S_REQ: begin
                    if (w_ack) begin
                        r_idx      <= r_idx + 7'd1;
                        r_mem_addr <= r_mem_addr + 16'd1;
                    end
                    // An abort never drops a pending request: it is drained first
                    if (frame_start || row_swap) begin
                        if (w_ack) begin
                            r_state   <= S_RESTART;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (w_ack && (r_idx == C_LAST)) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_ack) begin
                        r_state   <= S_RESTART;
                        r_mem_req <= 1'b0;
                    end
                end
                S_RESTART: begin
                    if (!w_can_fetch)
                        r_state <= S_IDLE;
                end
                default: ;
            endcase

            if (w_start) begin
                r_state    <= S_REQ;
                r_idx      <= 7'd0;
                r_mem_addr <= w_base;
                r_mem_req  <= 1'b1;
                r_row_ptr  <= w_ptr + 5'd1;
                r_row_base <= w_base + C_STRIDE;
            end
        end
    end

    // Line buffers: the back buffer is the one not selected for display
    always_ff @(posedge clock) begin
        if (w_ack && (r_state == S_REQ)) begin
            if (r_front_sel)
                r_buf0[r_idx] <= mem_data;
            else
                r_buf1[r_idx] <= mem_data;
        end
    end

    assign w_front_byte = r_front_sel ? r_buf1[col] : r_buf0[col];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_char_code <= 8'd0;
        else
            r_char_code <= (col < C_COLS) ? w_front_byte : 8'd0;
    end

`ifdef VG75_ROWFETCH_CURSOR_EN
    logic [4:0] r_disp_row;
    logic       r_cursor;

    // Starts at 31 so the first row_swap of a frame lands on row 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_disp_row <= 5'h1F;
            r_cursor   <= 1'b0;
        end else begin
            if (frame_start)
                r_disp_row <= 5'h1F;
            else if (row_swap)
                r_disp_row <= r_disp_row + 5'd1;
            r_cursor <= (r_disp_row == cursor_row) && (col == cursor_col);
        end
    end

    assign cursor = r_cursor;
`endif

    assign char_code  = r_char_code;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign fetch_busy = (r_state != S_IDLE);
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_vg75_rowfetch.sv
// Scoreboard bench for vg75_rowfetch: expected read addresses are queued when a
// fetch is triggered and checked against every acknowledged request.
module tb_vg75_rowfetch;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        row_swap = 1'b0;
    logic [6:0]  col = 7'd0;
    logic [7:0]  char_code;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        fetch_busy;
    logic        underrun;
`ifdef VG75_ROWFETCH_CURSOR_EN
    logic [4:0]  cursor_row = 5'd3;
    logic [6:0]  cursor_col = 7'd10;
    logic        cursor;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_ack = 0;
    int          wait_n = 2;
    logic        ack_en = 1'b1;
    int          cnt = 0;
    int          m_ptr = 0;
    logic [15:0] q_exp [$];

    vg75_rowfetch dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .row_swap    (row_swap),
        .col         (col),
`ifdef VG75_ROWFETCH_CURSOR_EN
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col),
        .cursor      (cursor),
`endif
        .char_code   (char_code),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .fetch_busy  (fetch_busy),
        .underrun    (underrun)
    );

    always #5 clock = ~clock;

    // Memory model: ack wait_n cycles after the request is seen, data = addr[7:0]
    assign mem_ack  = mem_req && ack_en && (cnt >= wait_n);
    assign mem_data = mem_addr[7:0];

    always @(posedge clock) begin
        if (!mem_req || mem_ack)
            cnt <= 0;
        else
            cnt <= cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && mem_req && mem_ack) begin
            n_ack++;
            if (q_exp.size() == 0)
                chk("unexpected_req", 32'(mem_addr), 32'hFFFF_FFFF);
            else
                chk("req_addr", 32'(mem_addr), 32'(q_exp.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_row(input int r);
        for (int c = 0; c < 80; c++)
            q_exp.push_back(16'(16'h76D0 + r * 80 + c));
    endtask

    // Keep only the request already on the bus; it will still be acknowledged
    task automatic keep_outstanding();
        logic [15:0] f;
        if (q_exp.size() > 0) begin
            f = q_exp[0];
            q_exp.delete();
            q_exp.push_back(f);
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_swap();
        row_swap = 1'b1;
        tick();
        row_swap = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (fetch_busy && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000)
            chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_addr(input logic [15:0] a);
        int n = 0;
        while (mem_addr != a && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000)
            chk("addr_timeout", 32'(mem_addr), 32'(a));
    endtask

    initial begin
        int nb;
        logic [15:0] held;

        // reset state
        tick();
        tick();
        chk("rst_char", 32'(char_code), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h76D0);
        chk("rst_busy", 32'(fetch_busy), 32'h0);
        chk("rst_underrun", 32'(underrun), 32'h0);
        reset_n = 1'b1;
        tick();

        // row 0 fetch with two-cycle memory, then display it
        wait_n = 2;
        push_row(0);
        pulse_fs();
        chk("busy_start", 32'(fetch_busy), 32'h1);
        wait_idle();
        chk("busy_drop", 32'(fetch_busy), 32'h0);
        chk("q_empty_row0", 32'(q_exp.size()), 32'd0);
        col = 7'd5;
        push_row(1);
        pulse_swap();
        tick();
        chk("char_col5", 32'(char_code), 32'hD5);
        col = 7'd0;
        tick();
        chk("char_col0", 32'(char_code), 32'hD0);
        col = 7'd79;
        tick();
        chk("char_col79", 32'(char_code), 32'h1F);
        col = 7'd80;
        tick();
        chk("char_col80", 32'(char_code), 32'h00);
        col = 7'd127;
        tick();
        chk("char_col127", 32'(char_code), 32'h00);
        wait_idle();

        // zero-wait memory: 80 back-to-back acks
        wait_n = 0;
        push_row(0);
        pulse_fs();
        nb = 0;
        while (fetch_busy && nb < 500) begin
            tick();
            nb++;
        end
        chk("zw_cycles", 32'(nb), 32'd80);
        push_row(1);
        pulse_swap();
        chk("zw_row1_addr", 32'(mem_addr), 32'h7720);
        wait_idle();

        // underrun: row_swap in the middle of row 1
        wait_n = 2;
        push_row(0);
        pulse_fs();
        wait_idle();
        push_row(1);
        pulse_swap();
        wait_addr(16'h7748);
        keep_outstanding();
        push_row(2);
        pulse_swap();
        chk("underrun_set", 32'(underrun), 32'h1);
        wait_idle();
        chk("underrun_sticky", 32'(underrun), 32'h1);
        chk("q_empty_ur", 32'(q_exp.size()), 32'd0);

        // frame_start with an outstanding request held off by memory
        push_row(0);
        pulse_fs();
        chk("underrun_clear", 32'(underrun), 32'h0);
        wait_addr(16'h76D5);
        ack_en = 1'b0;
        held = mem_addr;
        keep_outstanding();
        push_row(0);
        pulse_fs();
        for (int i = 0; i < 10; i++) begin
            chk("drain_addr", 32'(mem_addr), 32'h76D5);
            chk("drain_req", 32'(mem_req), 32'h1);
            tick();
        end
        ack_en = 1'b1;
        wait_idle();
        chk("q_empty_drain", 32'(q_exp.size()), 32'd0);

        // full frame: 26 swaps, 25 fetches
        wait_n = 0;
        n_ack = 0;
        push_row(0);
        m_ptr = 1;
        pulse_fs();
        wait_idle();
        for (int i = 0; i < 26; i++) begin
            if (m_ptr < 25) begin
                push_row(m_ptr);
                m_ptr++;
            end
            pulse_swap();
            wait_idle();
            if (i == 0 || i == 12 || i == 24) begin
                col = 7'd1;
                tick();
                chk("frame_char", 32'(char_code), 32'(8'(16'h76D0 + i * 80 + 1)));
            end
`ifdef VG75_ROWFETCH_CURSOR_EN
            if (i == 2 || i == 3) begin
                col = 7'd10;
                tick();
                chk("cursor_hit", 32'(cursor), (i == 3) ? 32'd1 : 32'd0);
                col = 7'd11;
                tick();
                chk("cursor_col_miss", 32'(cursor), 32'd0);
            end
`endif
        end
        for (int i = 0; i < 20; i++) begin
            if (mem_req)
                chk("req_after_frame", 32'(mem_req), 32'd0);
            tick();
        end
        chk("frame_acks", 32'(n_ack), 32'd2000);
        chk("frame_req_idle", 32'(mem_req), 32'd0);
        chk("q_empty_frame", 32'(q_exp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
